ksm_wb_arb: RTL and testbench
=============================

Name: ksm_wb_arb

Overview:
Two-master Wishbone arbiter that shares the terminal's single 16-bit peripheral bus (RAM, video RAM, vregs, UART, PS/2) between the К1801ВМ2 CPU (master 0) and a hardware video scroll/fill engine (master 1). It sits between the masters and the existing address decoder and ack-OR tree.
- Grants the bus per Wishbone cycle (cyc-held, so RMW and burst sequences are atomic).
- Arbitrates round-robin.
- Terminates hung slave cycles with a bus-timeout error, which the CPU uses for its trap-to-4.

Parameters:
- TIMEOUT, 64: cycles of stb-without-ack before err is raised; legal range 4..255.
- M0_PRIO, 0: if 1, master 0 always wins simultaneous requests (fixed priority); if 0, round-robin.

Ports:
- wb_clk_i  in  1  system clock, 50 MHz
- wb_rst_i  in  1  synchronous active-high reset
- m0_adr_i  in  16  master 0 address
- m0_dat_i  in  16  master 0 write data
- m0_dat_o  out  16  master 0 read data
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 cycle, strobe, write enable
- m0_sel_i  in  2  master 0 byte selects
- m0_ack_o, m0_err_o  out  1 each  master 0 ack, bus-timeout error
- m1_*: same set and widths as m0_*, for master 1
- s_adr_o  out  16  slave-side address
- s_dat_o  out  16  slave-side write data
- s_dat_i  in  16  slave-side read data (wb_mux)
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side cycle, strobe, write enable
- s_sel_o  out  2  slave-side byte selects
- s_ack_i  in  1  slave-side ack (wb_ack)
- gnt_o  out  2  one-hot current owner; 00 means idle
- tmo_o  out  1  one-cycle pulse on every timeout, for a status register

Behaviour:
- Reset (sync, wb_rst_i=1 at clock edge):
  - State goes to IDLE; gnt_o=00.
  - last-served is set to master 1, so master 0 wins the first tie.
  - All *_ack_o, *_err_o, tmo_o, s_cyc_o, s_stb_o are 0; the timeout counter is 0.
  - Reset mid-cycle drops the grant immediately, with no ack or err to the master.
- State machine: IDLE, OWN0, OWN1, ERR. The owner field is registered; gnt_o is driven directly from it.
- IDLE:
  - Only m0_cyc → OWN0. Only m1_cyc → OWN1.
  - Both requesting: if M0_PRIO, OWN0; else the master not last-served wins.
  - Grant latency: request visible at edge N, grant effective from edge N+1. The arbiter adds no wait state after the grant.
- OWNx:
  - Slave outputs s_adr/dat/we/sel/cyc/stb are a combinational mux of master x.
  - mx_ack_o = s_ack_i; mx_dat_o = s_dat_i.
  - The non-owner sees ack=0, err=0, dat_o=0.
  - Ownership persists while mx_cyc_i=1, independent of stb; stb may drop between transfers.
  - Owner drops cyc at edge N: last-served := x, and the next state is chosen at that same edge by the IDLE rules. Direct handoff to the other master is allowed with zero dead cycles.
  - If nobody is requesting, the next state is IDLE.
- Timeout counter (8 bits):
  - Cleared when not in OWNx, when s_stb_o=0, or when s_ack_i=1.
  - Otherwise increments each cycle.
  - When the counter reaches TIMEOUT-1 with stb=1 and ack=0: next state ERR, mx_err_o=1 for exactly one cycle (the first ERR cycle), tmo_o=1 the same cycle.
  - An ack arriving in the same cycle the count reaches TIMEOUT-1 wins: normal ack, no error.
- ERR:
  - s_cyc_o=s_stb_o=0, so the slave is isolated.
  - Any late s_ack_i is swallowed and not forwarded.
  - Stays in ERR until the faulted master drops cyc, then arbitrates as from OWNx release, with last-served = faulted master.
- Invariants:
  - At most one of gnt_o bits set.
  - ack and err are never both asserted to the same master.
  - s_cyc_o=0 whenever gnt_o=00 or the state is ERR.
- Fairness: with both masters continuously re-requesting, grants alternate 0,1,0,1 when M0_PRIO=0.

Decomposition:
- Package ksm_bus_pkg:
  - State encoding localparams IDLE/OWN0/OWN1/ERR.
  - Widths ADR_W=16, DAT_W=16, SEL_W=2.
  - Default TIMEOUT.
- Sub-module ksm_wb_tmo: the timeout counter with inputs clr, run, ack and output expire.
- The mux and state machine stay in ksm_wb_arb.

Test Plan:
1. Single master: m0 reads 0o170000 with ack 2 cycles after stb → grant at edge+1, m0_ack_o tracks s_ack_i, gnt_o=01, m1 sees ack=0 and dat=0.
2. Simultaneous request after reset, M0_PRIO=0 → OWN0 first; on m0 cyc drop, direct handoff to OWN1 in the same edge (no idle cycle); next tie → OWN0 again.
3. Atomic RMW: m0 holds cyc across read+write with stb gap, m1 requests throughout → m1 receives no grant until m0_cyc drops.
4. Timeout, TIMEOUT=8: m1 writes an unmapped address, never acked → m1_err_o and tmo_o pulse exactly one cycle, 8 cycles after stb rises; s_cyc_o=0 during ERR; a late ack injected in ERR is not seen by m1.
5. Ack on the expire cycle (ack at cycle TIMEOUT-1) → normal ack, err=0, tmo_o=0.
6. wb_rst_i asserted mid-transfer in OWN1 → next cycle gnt_o=00 and s_cyc_o=0; first tie after reset is won by m0; M0_PRIO=1 run confirms m0 always wins ties.

Source files
------------

// File: rtl/ksm_bus_pkg.sv
// Shared widths, arbiter state encoding and grant selection for the terminal's
// 16-bit Wishbone peripheral bus.
package ksm_bus_pkg;

    localparam int unsigned ADR_W       = 16;
    localparam int unsigned DAT_W       = 16;
    localparam int unsigned SEL_W       = 2;
    localparam int unsigned TMO_W       = 8;
    localparam int unsigned TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        ERR  = 2'd3
    } arb_state_e;

    // One master's request side of the bus, as presented to the slave mux
    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
        logic             we;
        logic [SEL_W-1:0] sel;
        logic             cyc;
        logic             stb;
    } wb_req_t;

    // Grant choice from idle; last_m1 set means master 1 was served last
    function automatic arb_state_e arb_pick(input logic c0, input logic c1,
                                            input logic last_m1, input logic m0_prio);
        arb_state_e s;
        s = IDLE;
        if (c0 && c1) begin
            s = (m0_prio || last_m1) ? OWN0 : OWN1;
        end else if (c0) begin
            s = OWN0;
        end else if (c1) begin
            s = OWN1;
        end
        return s;
    endfunction

endpackage

// File: rtl/ksm_wb_arb_if.sv
// Point-to-point Wishbone bundle; master drives the request, slave the response.
interface ksm_wb_arb_if;
    import ksm_bus_pkg::*;

    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat_w;
    logic [DAT_W-1:0] dat_r;
    logic             cyc;
    logic             stb;
    logic             we;
    logic [SEL_W-1:0] sel;
    logic             ack;
    logic             err;

    modport master (output adr, dat_w, cyc, stb, we, sel, input dat_r, ack, err);
    modport slave  (input adr, dat_w, cyc, stb, we, sel, output dat_r, ack, err);

endinterface

// File: rtl/ksm_wb_tmo.sv
// Bus-timeout counter: counts strobed-but-unacked cycles and flags the expiring one.
module ksm_wb_tmo
    import ksm_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic run_i,
    input  logic ack_i,
    output logic expire_c_o
);

    localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + TMO_W'(1);
        if (clr_i || !run_i || ack_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // An ack landing on the last count wins over the timeout
    assign expire_c_o = run_i && !clr_i && !ack_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/ksm_wb_arb.sv
// Two-master Wishbone arbiter (CPU = m0, video engine = m1) with cyc-held grants,
// round-robin or m0-priority tie breaking, and a slave-hang timeout.
module ksm_wb_arb
    import ksm_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter bit          M0_PRIO = 1'b0
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,

    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    output logic [DAT_W-1:0] m0_dat_o,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [SEL_W-1:0] m0_sel_i,
    output logic             m0_ack_o,
    output logic             m0_err_o,

    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    output logic [DAT_W-1:0] m1_dat_o,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [SEL_W-1:0] m1_sel_i,
    output logic             m1_ack_o,
    output logic             m1_err_o,

    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    input  logic [DAT_W-1:0] s_dat_i,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [SEL_W-1:0] s_sel_o,
    input  logic             s_ack_i,

    output logic [1:0]       gnt_o,
    output logic             tmo_o
);

    arb_state_e state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic       last_q,  last_d;
    logic [1:0] err_q,   err_d;
    logic       tmo_q,   tmo_d;

    wb_req_t m0_req, m1_req, s_req;
    logic    own0, own1;
    logic    tmo_expire_c;

    assign m0_req = '{adr: m0_adr_i, dat: m0_dat_i, we: m0_we_i, sel: m0_sel_i,
                      cyc: m0_cyc_i, stb: m0_stb_i};
    assign m1_req = '{adr: m1_adr_i, dat: m1_dat_i, we: m1_we_i, sel: m1_sel_i,
                      cyc: m1_cyc_i, stb: m1_stb_i};

    assign own0 = (state_q == OWN0);
    assign own1 = (state_q == OWN1);

    // Slave sees the owner only; idle and ERR isolate the slave completely
    always_comb begin
        s_req = '0;
        if (own0) begin
            s_req = m0_req;
        end else if (own1) begin
            s_req = m1_req;
        end
    end

    assign s_adr_o = s_req.adr;
    assign s_dat_o = s_req.dat;
    assign s_we_o  = s_req.we;
    assign s_sel_o = s_req.sel;
    assign s_cyc_o = s_req.cyc;
    assign s_stb_o = s_req.stb;

    assign m0_ack_o = own0 && s_ack_i;
    assign m1_ack_o = own1 && s_ack_i;
    assign m0_dat_o = own0 ? s_dat_i : '0;
    assign m1_dat_o = own1 ? s_dat_i : '0;
    assign m0_err_o = err_q[0];
    assign m1_err_o = err_q[1];
    assign gnt_o    = owner_q;
    assign tmo_o    = tmo_q;

    ksm_wb_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk_i      (wb_clk_i),
        .rst_i      (wb_rst_i),
        .clr_i      (!(own0 || own1)),
        .run_i      (s_cyc_o && s_stb_o),
        .ack_i      (s_ack_i),
        .expire_c_o (tmo_expire_c)
    );

    // Next state: releasing master becomes last-served, then idle rules apply same edge
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        err_d   = '0;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = arb_pick(m0_cyc_i, m1_cyc_i, last_q, M0_PRIO);
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    last_d  = 1'b0;
                    state_d = arb_pick(m0_cyc_i, m1_cyc_i, 1'b0, M0_PRIO);
                end else if (tmo_expire_c) begin
                    state_d = ERR;
                    err_d   = 2'b01;
                    tmo_d   = 1'b1;
                end
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    last_d  = 1'b1;
                    state_d = arb_pick(m0_cyc_i, m1_cyc_i, 1'b1, M0_PRIO);
                end else if (tmo_expire_c) begin
                    state_d = ERR;
                    err_d   = 2'b10;
                    tmo_d   = 1'b1;
                end
            end
            ERR: begin
                if (owner_q[1] ? !m1_cyc_i : !m0_cyc_i) begin
                    last_d  = owner_q[1];
                    state_d = arb_pick(m0_cyc_i, m1_cyc_i, owner_q[1], M0_PRIO);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        owner_d = owner_q;
        case (state_d)
            IDLE:    owner_d = 2'b00;
            OWN0:    owner_d = 2'b01;
            OWN1:    owner_d = 2'b10;
            default: owner_d = owner_q;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            owner_q <= 2'b00;
            last_q  <= 1'b1;
            err_q   <= 2'b00;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_ksm_wb_arb.sv
// Scoreboard bench for ksm_wb_arb: round-robin instance drives the checks,
// an m0-priority instance shares the master stimulus for tie-break checks.
module tb_ksm_wb_arb;
    import ksm_bus_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    ksm_wb_arb_if m0_b ();
    ksm_wb_arb_if m1_b ();
    ksm_wb_arb_if s_b ();

    logic [1:0] gnt_a, gnt_b;
    logic       tmo_a, tmo_b;

    logic [DAT_W-1:0] b_m0_dat, b_m1_dat, b_s_dat;
    logic [ADR_W-1:0] b_s_adr;
    logic [SEL_W-1:0] b_s_sel;
    logic             b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;
    logic             b_s_cyc, b_s_stb, b_s_we;

    // Slave model: reads return address xor a pattern, writes return zero
    assign s_b.dat_r = s_b.we ? 16'h0000 : (s_b.adr ^ 16'h5A5A);
    assign s_b.err   = 1'b0;

    ksm_wb_arb #(.TIMEOUT(8), .M0_PRIO(1'b0)) dut_a (
        .wb_clk_i (clk),         .wb_rst_i (rst),
        .m0_adr_i (m0_b.adr),    .m0_dat_i (m0_b.dat_w), .m0_dat_o (m0_b.dat_r),
        .m0_cyc_i (m0_b.cyc),    .m0_stb_i (m0_b.stb),   .m0_we_i  (m0_b.we),
        .m0_sel_i (m0_b.sel),    .m0_ack_o (m0_b.ack),   .m0_err_o (m0_b.err),
        .m1_adr_i (m1_b.adr),    .m1_dat_i (m1_b.dat_w), .m1_dat_o (m1_b.dat_r),
        .m1_cyc_i (m1_b.cyc),    .m1_stb_i (m1_b.stb),   .m1_we_i  (m1_b.we),
        .m1_sel_i (m1_b.sel),    .m1_ack_o (m1_b.ack),   .m1_err_o (m1_b.err),
        .s_adr_o  (s_b.adr),     .s_dat_o  (s_b.dat_w),  .s_dat_i  (s_b.dat_r),
        .s_cyc_o  (s_b.cyc),     .s_stb_o  (s_b.stb),    .s_we_o   (s_b.we),
        .s_sel_o  (s_b.sel),     .s_ack_i  (s_b.ack),
        .gnt_o    (gnt_a),       .tmo_o    (tmo_a)
    );

    ksm_wb_arb #(.TIMEOUT(8), .M0_PRIO(1'b1)) dut_b (
        .wb_clk_i (clk),         .wb_rst_i (rst),
        .m0_adr_i (m0_b.adr),    .m0_dat_i (m0_b.dat_w), .m0_dat_o (b_m0_dat),
        .m0_cyc_i (m0_b.cyc),    .m0_stb_i (m0_b.stb),   .m0_we_i  (m0_b.we),
        .m0_sel_i (m0_b.sel),    .m0_ack_o (b_m0_ack),   .m0_err_o (b_m0_err),
        .m1_adr_i (m1_b.adr),    .m1_dat_i (m1_b.dat_w), .m1_dat_o (b_m1_dat),
        .m1_cyc_i (m1_b.cyc),    .m1_stb_i (m1_b.stb),   .m1_we_i  (m1_b.we),
        .m1_sel_i (m1_b.sel),    .m1_ack_o (b_m1_ack),   .m1_err_o (b_m1_err),
        .s_adr_o  (b_s_adr),     .s_dat_o  (b_s_dat),    .s_dat_i  (16'h0000),
        .s_cyc_o  (b_s_cyc),     .s_stb_o  (b_s_stb),    .s_we_o   (b_s_we),
        .s_sel_o  (b_s_sel),     .s_ack_i  (1'b0),
        .gnt_o    (gnt_b),       .tmo_o    (tmo_b)
    );

    int n_chk = 0;
    int n_err = 0;

    typedef struct packed {
        logic        mst;
        logic        err;
        logic [15:0] dat;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [15:0] adr);
        if (m == 0) begin
            m0_b.cyc = cyc; m0_b.stb = stb; m0_b.we = we; m0_b.adr = adr;
            m0_b.dat_w = ~adr; m0_b.sel = 2'b11;
        end else begin
            m1_b.cyc = cyc; m1_b.stb = stb; m1_b.we = we; m1_b.adr = adr;
            m1_b.dat_w = ~adr; m1_b.sel = 2'b11;
        end
    endtask

    task automatic push(input logic m, input logic err, input logic we, input logic [15:0] adr);
        exp_t e;
        e.mst = m;
        e.err = err;
        e.dat = (err || we) ? 16'h0000 : (adr ^ 16'h5A5A);
        sb_q.push_back(e);
    endtask

    task automatic mon(input logic m, input logic ack, input logic err, input logic [15:0] dat);
        exp_t e;
        if (ack || err) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", 32'(sb_q.size()), 1);
            end else begin
                e = sb_q.pop_front();
                chk("sb_master", 32'(m), 32'(e.mst));
                chk("sb_err", 32'(err), 32'(e.err));
                chk("sb_ack", 32'(ack), 32'(!e.err));
                if (!e.err) chk("sb_dat", 32'(dat), 32'(e.dat));
            end
        end
    endtask

    // Response monitor and bus invariants, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            chk("inv_gnt_onehot", 32'($countones(gnt_a) <= 1), 1);
            chk("inv_cyc_idle", 32'(s_b.cyc && (gnt_a == 2'b00)), 0);
            chk("inv_ack_err0", 32'(m0_b.ack && m0_b.err), 0);
            chk("inv_ack_err1", 32'(m1_b.ack && m1_b.err), 0);
        end
        mon(1'b0, m0_b.ack, m0_b.err, m0_b.dat_r);
        mon(1'b1, m1_b.ack, m1_b.err, m1_b.dat_r);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        s_b.ack = 1'b0;
        drv(0, 0, 0, 0, 16'h0);
        drv(1, 0, 0, 0, 16'h0);
        tick(); tick();
        chk("rst_gnt", 32'(gnt_a), 0);
        chk("rst_scyc", 32'(s_b.cyc), 0);
        chk("rst_sstb", 32'(s_b.stb), 0);
        chk("rst_tmo", 32'(tmo_a), 0);
        chk("rst_errs", 32'({m0_b.err, m1_b.err}), 0);
        rst = 1'b0;

        // Single master read, ack two cycles after grant
        drv(0, 1, 1, 0, 16'o170000);
        #1 chk("t1_no_early_gnt", 32'(gnt_a), 0);
        tick();
        chk("t1_gnt", 32'(gnt_a), 1);
        chk("t1_sadr", 32'(s_b.adr), 32'o170000);
        chk("t1_scyc", 32'(s_b.cyc), 1);
        push(1'b0, 1'b0, 1'b0, 16'o170000);
        tick(); tick();
        s_b.ack = 1'b1;
        #1;
        chk("t1_m0_ack", 32'(m0_b.ack), 1);
        chk("t1_m1_ack", 32'(m1_b.ack), 0);
        chk("t1_m1_dat", 32'(m1_b.dat_r), 0);
        tick();
        s_b.ack = 1'b0;
        drv(0, 0, 0, 0, 16'h0);
        #1 chk("t1_ack_drop", 32'(m0_b.ack), 0);
        tick();
        chk("t1_idle", 32'(gnt_a), 0);

        // Ties after reset: m0 first, direct handoff, then m0 again
        rst = 1'b1; tick(); rst = 1'b0;
        drv(0, 1, 1, 0, 16'h1000);
        drv(1, 1, 1, 0, 16'h2000);
        tick();
        chk("t2_tie_m0", 32'(gnt_a), 1);
        push(1'b0, 1'b0, 1'b0, 16'h1000);
        s_b.ack = 1'b1;
        tick();
        s_b.ack = 1'b0;
        drv(0, 0, 0, 0, 16'h0);
        tick();
        chk("t2_handoff", 32'(gnt_a), 2);
        chk("t2_sadr", 32'(s_b.adr), 32'h2000);
        push(1'b1, 1'b0, 1'b0, 16'h2000);
        s_b.ack = 1'b1;
        tick();
        s_b.ack = 1'b0;
        drv(1, 0, 0, 0, 16'h0);
        tick();
        chk("t2_idle", 32'(gnt_a), 0);
        drv(0, 1, 1, 0, 16'h1002);
        drv(1, 1, 1, 0, 16'h2002);
        tick();
        chk("t2_tie2_m0", 32'(gnt_a), 1);
        push(1'b0, 1'b0, 1'b0, 16'h1002);
        s_b.ack = 1'b1;
        tick();
        s_b.ack = 1'b0;
        drv(0, 0, 0, 0, 16'h0);
        tick();
        chk("t2_alternate", 32'(gnt_a), 2);
        push(1'b1, 1'b0, 1'b0, 16'h2002);
        s_b.ack = 1'b1;
        tick();
        s_b.ack = 1'b0;
        drv(1, 0, 0, 0, 16'h0);
        tick();

        // Atomic read-modify-write by m0 while m1 waits
        drv(0, 1, 1, 0, 16'h3000);
        tick();
        chk("t3_gnt", 32'(gnt_a), 1);
        drv(1, 1, 1, 1, 16'h4000);
        push(1'b0, 1'b0, 1'b0, 16'h3000);
        s_b.ack = 1'b1;
        tick();
        s_b.ack = 1'b0;
        drv(0, 1, 0, 0, 16'h3000);
        tick();
        chk("t3_gap_gnt", 32'(gnt_a), 1);
        chk("t3_gap_stb", 32'(s_b.stb), 0);
        tick();
        chk("t3_gap_gnt2", 32'(gnt_a), 1);
        drv(0, 1, 1, 1, 16'h3000);
        push(1'b0, 1'b0, 1'b1, 16'h3000);
        tick();
        chk("t3_hold", 32'(gnt_a), 1);
        chk("t3_swe", 32'(s_b.we), 1);
        chk("t3_sdat", 32'(s_b.dat_w), 32'hCFFF);
        s_b.ack = 1'b1;
        #1 chk("t3_m1_noack", 32'(m1_b.ack), 0);
        tick();
        s_b.ack = 1'b0;
        drv(0, 0, 0, 0, 16'h0);
        tick();
        chk("t3_m1_gnt", 32'(gnt_a), 2);
        chk("t3_m1_sadr", 32'(s_b.adr), 32'h4000);
        push(1'b1, 1'b0, 1'b1, 16'h4000);
        s_b.ack = 1'b1;
        tick();
        s_b.ack = 1'b0;
        drv(1, 0, 0, 0, 16'h0);
        tick();
        chk("t3_idle", 32'(gnt_a), 0);

        // Timeout on an unmapped write by m1
        drv(1, 1, 1, 1, 16'hDEAD);
        tick();
        chk("t4_gnt", 32'(gnt_a), 2);
        push(1'b1, 1'b1, 1'b1, 16'hDEAD);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("t4_no_early_err", 32'({m1_b.err, tmo_a}), 0);
        end
        tick();
        chk("t4_err", 32'(m1_b.err), 1);
        chk("t4_tmo", 32'(tmo_a), 1);
        chk("t4_m0_err", 32'(m0_b.err), 0);
        chk("t4_scyc", 32'(s_b.cyc), 0);
        chk("t4_sstb", 32'(s_b.stb), 0);
        s_b.ack = 1'b1;
        #1 chk("t4_late_ack", 32'(m1_b.ack), 0);
        tick();
        s_b.ack = 1'b0;
        chk("t4_err_pulse", 32'(m1_b.err), 0);
        chk("t4_tmo_pulse", 32'(tmo_a), 0);
        chk("t4_hold_scyc", 32'(s_b.cyc), 0);
        chk("t4_hold_gnt", 32'(gnt_a), 2);
        drv(1, 0, 0, 0, 16'h0);
        tick();
        chk("t4_release", 32'(gnt_a), 0);

        // Ack on the expiring count beats the timeout
        drv(0, 1, 1, 0, 16'h5000);
        tick();
        chk("t5_gnt", 32'(gnt_a), 1);
        push(1'b0, 1'b0, 1'b0, 16'h5000);
        for (int i = 1; i < 8; i++) tick();
        s_b.ack = 1'b1;
        #1;
        chk("t5_ack", 32'(m0_b.ack), 1);
        chk("t5_no_err", 32'(m0_b.err), 0);
        tick();
        s_b.ack = 1'b0;
        chk("t5_no_err_after", 32'(m0_b.err), 0);
        chk("t5_no_tmo", 32'(tmo_a), 0);
        chk("t5_gnt_kept", 32'(gnt_a), 1);
        drv(0, 0, 0, 0, 16'h0);
        tick();

        // Reset while m1 owns the bus; first tie afterwards goes to m0
        drv(1, 1, 1, 0, 16'h6000);
        tick();
        chk("t6_gnt", 32'(gnt_a), 2);
        rst = 1'b1;
        tick();
        chk("t6_rst_gnt", 32'(gnt_a), 0);
        chk("t6_rst_scyc", 32'(s_b.cyc), 0);
        chk("t6_rst_m1", 32'({m1_b.ack, m1_b.err}), 0);
        drv(0, 1, 0, 0, 16'h0);
        drv(1, 1, 0, 0, 16'h0);
        rst = 1'b0;
        tick();
        chk("t6_tie_rr", 32'(gnt_a), 1);
        chk("t6_tie_prio", 32'(gnt_b), 1);
        drv(0, 0, 0, 0, 16'h0);
        tick();
        chk("t6_handoff_rr", 32'(gnt_a), 2);
        chk("t6_handoff_prio", 32'(gnt_b), 2);
        drv(1, 0, 0, 0, 16'h0);
        tick();
        drv(0, 1, 0, 0, 16'h0);
        tick();
        chk("t6_solo_m0", 32'(gnt_b), 1);
        drv(0, 0, 0, 0, 16'h0);
        tick();
        chk("t6_idle_prio", 32'(gnt_b), 0);
        drv(0, 1, 0, 0, 16'h0);
        drv(1, 1, 0, 0, 16'h0);
        tick();
        chk("t6_rr_after_m0", 32'(gnt_a), 2);
        chk("t6_prio_after_m0", 32'(gnt_b), 1);
        drv(0, 0, 0, 0, 16'h0);
        drv(1, 0, 0, 0, 16'h0);
        tick(); tick();

        chk("sb_drain", 32'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
